// File: rtl/serial_boot_bridge.sv
// serial_boot_bridge: serial boot loader plus CPU store-address serialiser.
//   RX side : bits on ser_in (qualified by rx_en, MSB first) are assembled into
//             bytes and written to instruction memory at a linearly increasing
//             load address. After LOAD_WORDS*DW/8 bytes the CPU owns imem
//             (boot_done) and imem_addr follows cpu_pc.
//   TX side : after boot, CPU store addresses are queued in a FIFO and sent
//             MSB first on tx_ser_out whenever tx_en allows.
// Optional feature: define TX_PARITY_EN to append an even-parity bit per frame.
// Ports:
//   clk, rst (async, active-high)
//   rx_en, ser_in                 : serial load input
//   cpu_pc                        : CPU fetch address (drives imem_addr after boot)
//   cpu_dmem_we, cpu_dmem_addr    : CPU store strobe / address
//   tx_en                         : TX serialiser may advance
//   imem_we, imem_wdata, imem_addr: instruction-memory byte write port
//   boot_done                     : sticky, load finished
//   tx_ser_out, tx_valid          : serial store-address stream
//   tx_ovf                        : sticky, a store was dropped on a full FIFO
module serial_boot_bridge #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned LOAD_WORDS = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_en,
  input  logic          ser_in,
  input  logic [AW-1:0] cpu_pc,
  input  logic          cpu_dmem_we,
  input  logic [AW-1:0] cpu_dmem_addr,
  input  logic          tx_en,
  output logic          imem_we,
  output logic [7:0]    imem_wdata,
  output logic [AW-1:0] imem_addr,
  output logic          boot_done,
  output logic          tx_ser_out,
  output logic          tx_valid,
  output logic          tx_ovf
);

  localparam int unsigned LOAD_BYTES = LOAD_WORDS * DW / 8;
  localparam int unsigned PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW       = PW + 1;
  localparam int unsigned BW         = (AW > 1) ? $clog2(AW) : 1;

  typedef enum logic {SHIFT, DONE} rx_state_t;

`ifdef TX_PARITY_EN
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_PAR} tx_state_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT} tx_state_t;
`endif

  rx_state_t       rx_state;
  logic [7:0]      rx_byte;
  logic [2:0]      bit_cnt;
  logic [AW-1:0]   load_addr;

  tx_state_t       tx_state;
  logic [AW-1:0]   tx_shreg;
  logic [BW-1:0]   tx_cnt;
`ifdef TX_PARITY_EN
  logic            tx_par;
`endif

  logic [AW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] fifo_cnt;

  logic            fifo_full_c;
  logic            fifo_empty_c;
  logic            push_req_c;
  logic            push_c;
  logic            pop_c;
  logic [AW-1:0]   fifo_head_c;

  // imem is owned by the loader until boot completes, then by the CPU fetch path
  assign imem_addr = boot_done ? cpu_pc : load_addr;

  // RX loader: byte assembly, write strobe, load address and boot handover
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= SHIFT;
      rx_byte    <= '0;
      bit_cnt    <= '0;
      load_addr  <= '0;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      boot_done  <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (rx_state)
        SHIFT: begin
          // shifting keeps running during the write cycle so no bit is lost
          if (rx_en) begin
            rx_byte <= {rx_byte[6:0], ser_in};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              imem_we    <= 1'b1;
              imem_wdata <= {rx_byte[6:0], ser_in};
            end
          end
          // address advances after the write; the final write hands over imem
          if (imem_we) begin
            if (load_addr == AW'(LOAD_BYTES - 1)) begin
              rx_state  <= DONE;
              boot_done <= 1'b1;
            end else begin
              load_addr <= load_addr + AW'(1);
            end
          end
        end
        DONE:    boot_done <= 1'b1;
        default: rx_state  <= SHIFT;
      endcase
    end
  end

  // FIFO control; a full FIFO still accepts a push when the TX side pops
  assign fifo_full_c  = (fifo_cnt == CNTW'(FIFO_DEPTH));
  assign fifo_empty_c = (fifo_cnt == '0);
  assign fifo_head_c  = fifo_mem[rd_ptr];
  assign pop_c        = (tx_state == TX_IDLE) && tx_en && !fifo_empty_c;
  assign push_req_c   = boot_done && cpu_dmem_we;
  assign push_c       = push_req_c && (!fifo_full_c || pop_c);

  // FIFO storage (no reset needed; occupancy is tracked by the counters)
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= cpu_dmem_addr;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      if (push_c)
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop_c)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push_c, pop_c})
        2'b10:   fifo_cnt <= fifo_cnt + CNTW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNTW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req_c && !push_c) tx_ovf <= 1'b1;
    end
  end

  // TX serialiser FSM; every transition, including the pop, waits for tx_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_shreg <= '0;
      tx_cnt   <= '0;
`ifdef TX_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (pop_c) begin
            tx_shreg <= fifo_head_c;
            tx_cnt   <= '0;
`ifdef TX_PARITY_EN
            tx_par   <= ^fifo_head_c;
`endif
            tx_state <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tx_en) begin
            tx_shreg <= tx_shreg << 1;
            if (tx_cnt == BW'(AW - 1)) begin
`ifdef TX_PARITY_EN
              tx_state <= TX_PAR;
`else
              tx_state <= TX_IDLE;
`endif
            end else begin
              tx_cnt <= tx_cnt + BW'(1);
            end
          end
        end
`ifdef TX_PARITY_EN
        TX_PAR: begin
          if (tx_en) tx_state <= TX_IDLE;
        end
`endif
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // TX line: a bit is presented in the same cycle tx_en grants it
  always_comb begin
    tx_valid   = 1'b0;
    tx_ser_out = 1'b0;
    case (tx_state)
      TX_SHIFT: begin
        tx_valid   = tx_en;
        tx_ser_out = tx_en & tx_shreg[AW-1];
      end
`ifdef TX_PARITY_EN
      TX_PAR: begin
        tx_valid   = tx_en;
        tx_ser_out = tx_en & tx_par;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_boot_bridge.sv
// Testbench for serial_boot_bridge (LOAD_WORDS=1, DW=AW=32, FIFO_DEPTH=4).
// Honours TX_PARITY_EN when the design is built with it.
`timescale 1ns/1ps
module tb_serial_boot_bridge;

  localparam int unsigned DW         = 32;
  localparam int unsigned AW         = 32;
  localparam int unsigned LOAD_WORDS = 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned NBYTES     = LOAD_WORDS * DW / 8;
`ifdef TX_PARITY_EN
  localparam int unsigned FRAME = AW + 1;
`else
  localparam int unsigned FRAME = AW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_en = 1'b0;
  logic          ser_in = 1'b0;
  logic [AW-1:0] cpu_pc = '0;
  logic          cpu_dmem_we = 1'b0;
  logic [AW-1:0] cpu_dmem_addr = '0;
  logic          tx_en = 1'b0;
  logic          imem_we;
  logic [7:0]    imem_wdata;
  logic [AW-1:0] imem_addr;
  logic          boot_done;
  logic          tx_ser_out;
  logic          tx_valid;
  logic          tx_ovf;

  serial_boot_bridge #(
    .DW(DW), .AW(AW), .LOAD_WORDS(LOAD_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .ser_in(ser_in), .cpu_pc(cpu_pc),
    .cpu_dmem_we(cpu_dmem_we), .cpu_dmem_addr(cpu_dmem_addr), .tx_en(tx_en),
    .imem_we(imem_we), .imem_wdata(imem_wdata), .imem_addr(imem_addr),
    .boot_done(boot_done), .tx_ser_out(tx_ser_out), .tx_valid(tx_valid),
    .tx_ovf(tx_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed traffic
  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];
  int            wr_cyc_q[$];
  int            exp_wr_cyc_q[$];
  logic          tx_bits_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            boot_cyc   = -1;
  logic          boot_prev  = 1'b0;
  int            valid_viol = 0;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (tx_valid === 1'b1) tx_bits_q.push_back(tx_ser_out);
    if (tx_valid === 1'b1 && tx_en !== 1'b1) valid_viol++;
    if (boot_done === 1'b1 && boot_prev !== 1'b1) boot_cyc = cyc;
    boot_prev = boot_done;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_en = 1'b0; ser_in = 1'b0; cpu_dmem_we = 1'b0;
    cpu_dmem_addr = '0; tx_en = 1'b0; cpu_pc = '0;
    repeat (2) tick();
    rst = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    exp_wr_cyc_q.delete(); tx_bits_q.delete(); exp_addr_q.delete();
    boot_cyc = -1; valid_viol = 0;
    tick();
  endtask

  // mode 0: rx_en always high; 1: idle cycle before every bit; 2: random idles
  task automatic send_byte(input logic [7:0] b, input int mode, input bit rand_store);
    for (int i = 7; i >= 0; i--) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        rx_en = 1'b0; ser_in = ~b[i];
        cpu_dmem_we = rand_store & 1'($urandom_range(0, 1)); cpu_dmem_addr = $urandom;
        tick();
      end
      rx_en = 1'b1; ser_in = b[i];
      cpu_dmem_we = rand_store & 1'($urandom_range(0, 1)); cpu_dmem_addr = $urandom;
      if (i == 0) exp_wr_cyc_q.push_back(cyc + 1);
      tick();
    end
    rx_en = 1'b0; cpu_dmem_we = 1'b0;
  endtask

  task automatic wait_boot(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = (boot_done === 1'b1);
    end
    check("boot_wait", 64'(ok), 64'd1);
  endtask

  task automatic boot();
    bit ok;
    do_reset();
    tx_en = 1'b1;
    for (int k = 0; k < int'(NBYTES); k++) send_byte(8'($urandom), 0, 1'b1);
    wait_boot(ok);
    tx_en = 1'b0;
    tick();
    tx_bits_q.delete(); exp_addr_q.delete();
  endtask

  task automatic store(input logic [AW-1:0] a);
    cpu_dmem_we = 1'b1; cpu_dmem_addr = a;
    tick();
    cpu_dmem_we = 1'b0;
  endtask

  // reference: each queued address becomes AW bits MSB first (+ even parity)
  task automatic frames_check(input string name);
    logic eb[$];
    int   bad = 0;
    int   n;
    foreach (exp_addr_q[k]) begin
      for (int i = AW - 1; i >= 0; i--) eb.push_back(exp_addr_q[k][i]);
`ifdef TX_PARITY_EN
      eb.push_back(^exp_addr_q[k]);
`endif
    end
    check({name, "_len"}, 64'(tx_bits_q.size()), 64'(eb.size()));
    n = (tx_bits_q.size() < eb.size()) ? tx_bits_q.size() : eb.size();
    for (int i = 0; i < n; i++) if (tx_bits_q[i] !== eb[i]) bad++;
    check({name, "_bits"}, 64'(bad), 64'd0);
  endtask

  typedef struct packed {
    logic [31:0] bytes;
    logic [1:0]  mode;
    logic [31:0] exp_bytes;
  } rx_vec_t;

  rx_vec_t tab [4];

  initial begin
    bit            ok;
    logic [AW-1:0] a;
    logic [63:0]   packed_bits;
    int            nwr;

    tab[0].bytes = 32'hDEADBEEF; tab[0].mode = 2'd0; tab[0].exp_bytes = 32'hDEADBEEF;
    tab[1].bytes = 32'hDEADBEEF; tab[1].mode = 2'd1; tab[1].exp_bytes = 32'hDEADBEEF;
    tab[2].bytes = 32'h00FF55A5; tab[2].mode = 2'd2; tab[2].exp_bytes = 32'h00FF55A5;
    a = $urandom;
    tab[3].bytes = a;            tab[3].mode = 2'd2; tab[3].exp_bytes = a;

    // asynchronous reset takes effect without a clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_imem_we",    64'(imem_we),    64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_boot_done",  64'(boot_done),  64'd0);
    check("rst_tx_ser_out", 64'(tx_ser_out), 64'd0);
    check("rst_tx_valid",   64'(tx_valid),   64'd0);
    check("rst_tx_ovf",     64'(tx_ovf),     64'd0);
    check("rst_imem_addr",  64'(imem_addr),  64'd0);

    // table-driven load vectors
    for (int t = 0; t < 4; t++) begin
      do_reset();
      tx_en = 1'b1;
      for (int k = 0; k < 4; k++) send_byte(tab[t].bytes[31-8*k -: 8], int'(tab[t].mode), 1'b1);
      wait_boot(ok);
      repeat (12) tick();
      check($sformatf("v%0d_nwr", t), 64'(wr_addr_q.size()), 64'd4);
      for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
        check($sformatf("v%0d_addr%0d", t, k), 64'(wr_addr_q[k]), 64'(k));
        check($sformatf("v%0d_data%0d", t, k), 64'(wr_data_q[k]), 64'(tab[t].exp_bytes[31-8*k -: 8]));
        check($sformatf("v%0d_wcyc%0d", t, k), 64'(wr_cyc_q[k]), 64'(exp_wr_cyc_q[k]));
      end
      if (wr_cyc_q.size() == 4)
        check($sformatf("v%0d_boot_cyc", t), 64'(boot_cyc), 64'(wr_cyc_q[3] + 1));
      check($sformatf("v%0d_no_pre_boot_tx", t), 64'(tx_bits_q.size()), 64'd0);
      check($sformatf("v%0d_ovf", t), 64'(tx_ovf), 64'd0);
    end

    // after boot: imem_addr follows cpu_pc combinationally, RX is ignored
    nwr = wr_addr_q.size();
    cpu_pc = 32'h40;
    #1 check("pc_follow_40", 64'(imem_addr), 64'h40);
    cpu_pc = 32'h1234;
    #1 check("pc_follow_1234", 64'(imem_addr), 64'h1234);
    for (int k = 0; k < 16; k++) begin
      rx_en = 1'b1; ser_in = 1'($urandom_range(0, 1));
      tick();
    end
    rx_en = 1'b0;
    repeat (2) tick();
    check("done_no_write", 64'(wr_addr_q.size()), 64'(nwr));
    check("done_sticky", 64'(boot_done), 64'd1);

    // reset after 13 bits: outputs clear at once, load restarts at address 0
    do_reset();
    send_byte(8'hDE, 0, 1'b0);
    for (int i = 7; i >= 3; i--) begin
      rx_en = 1'b1; ser_in = 1'(8'hAD >> i);
      tick();
    end
    rx_en = 1'b0;
    check("mid_load_addr", 64'(imem_addr), 64'd1);
    check("mid_load_wdata", 64'(imem_wdata), 64'hDE);
    #2 rst = 1'b1;
    #1;
    check("midrst_wdata", 64'(imem_wdata), 64'd0);
    check("midrst_we",    64'(imem_we),    64'd0);
    check("midrst_addr",  64'(imem_addr),  64'd0);
    check("midrst_boot",  64'(boot_done),  64'd0);
    do_reset();
    send_byte(8'h3C, 0, 1'b0);
    repeat (3) tick();
    check("restart_nwr", 64'(wr_addr_q.size()), 64'd1);
    if (wr_addr_q.size() > 0) begin
      check("restart_addr", 64'(wr_addr_q[0]), 64'd0);
      check("restart_data", 64'(wr_data_q[0]), 64'h3C);
    end

    // single store of 0x5
    boot();
    tx_en = 1'b1;
    store(32'h5);
    exp_addr_q.push_back(32'h5);
    repeat (45) tick();
    frames_check("st5");
    packed_bits = '0;
    foreach (tx_bits_q[i]) packed_bits = {packed_bits[62:0], tx_bits_q[i]};
    check("st5_value", packed_bits, (FRAME == AW) ? 64'h5 : 64'hA);

    // six stores into a stalled TX: four kept, overflow flagged
    boot();
    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      if (k < 4) exp_addr_q.push_back(a);
      cpu_dmem_we = 1'b1; cpu_dmem_addr = a;
      tick();
    end
    cpu_dmem_we = 1'b0;
    tick();
    check("ovf_set", 64'(tx_ovf), 64'd1);
    check("ovf_stalled", 64'(tx_bits_q.size()), 64'd0);
    tx_en = 1'b1;
    repeat (220) tick();
    frames_check("ovf_frames");
    check("ovf_sticky", 64'(tx_ovf), 64'd1);

    // push and pop together on a full FIFO both succeed
    boot();
    for (int k = 0; k < 4; k++) begin
      a = $urandom; exp_addr_q.push_back(a); store(a);
    end
    tick();
    check("full_no_ovf", 64'(tx_ovf), 64'd0);
    a = $urandom; exp_addr_q.push_back(a);
    tx_en = 1'b1;
    store(a);
    tick();
    check("pushpop_no_ovf", 64'(tx_ovf), 64'd0);
    repeat (260) tick();
    frames_check("pushpop_frames");

    // randomized bursts against the queue reference model
    boot();
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        a = $urandom; exp_addr_q.push_back(a);
        tx_en = ($urandom_range(0, 1) == 1);
        cpu_dmem_we = 1'b1; cpu_dmem_addr = a;
        tick();
        cpu_dmem_we = 1'b0;
        if ($urandom_range(0, 1) == 1) tick();
      end
      for (int k = 0; k < 300; k++) begin
        tx_en = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    tx_en = 1'b0;
    tick();
    frames_check("rand_frames");
    check("rand_no_ovf", 64'(tx_ovf), 64'd0);
    check("valid_gated", 64'(valid_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/serial_boot_bridge.md
SERIAL_BOOT_BRIDGE -- requirements
Module: serial_boot_bridge

Interface
REQ-001 SHALL have parameter DW, default 32: CPU data and PC width; SHALL be a multiple of 8.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter LOAD_WORDS, default 16: number of DW-bit instructions loaded before boot completes.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: TX queue entries; SHALL be a power of 2.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port rx_en, input, 1: ser_in is valid this cycle.
REQ-008 SHALL have port ser_in, input, 1: serial load data, byte MSB first.
REQ-009 SHALL have port cpu_pc, input, AW: CPU fetch address.
REQ-010 SHALL have port cpu_dmem_we, input, 1: CPU store strobe.
REQ-011 SHALL have port cpu_dmem_addr, input, AW: CPU store address.
REQ-012 SHALL have port tx_en, input, 1: TX serialiser may advance.
REQ-013 SHALL have port imem_we, output, 1: instruction-memory byte write strobe.
REQ-014 SHALL have port imem_wdata, output, 8: byte to write.
REQ-015 SHALL have port imem_addr, output, AW: instruction-memory address.
REQ-016 SHALL have port boot_done, output, 1: loading is complete and the CPU owns the instruction memory.
REQ-017 SHALL have port tx_ser_out, output, 1: serial store-address stream, MSB first.
REQ-018 SHALL have port tx_valid, output, 1: tx_ser_out carries a valid bit.
REQ-019 SHALL have port tx_ovf, output, 1: sticky flag; a store was dropped because the FIFO was full.

Function
REQ-020 RX FSM SHALL have states SHIFT and DONE, and SHALL reset to SHIFT.
REQ-021 In SHIFT, each cycle with rx_en=1 SHALL shift ser_in into the byte register and increment a 3-bit bit counter; cycles with rx_en=0 SHALL hold the byte register and bit counter.
REQ-022 On the cycle the 8th bit is sampled, the next cycle SHALL drive imem_we=1 for exactly one cycle, with imem_wdata equal to the assembled byte and imem_addr equal to the load address.
REQ-023 The load address SHALL start at 0, SHALL increment by 1 after each write, and SHALL NOT wrap.
REQ-024 Shifting SHALL continue, without losing bits, during the imem_we cycle.
REQ-025 After write number LOAD_WORDS*DW/8, the FSM SHALL enter DONE and boot_done SHALL rise on the next cycle; boot_done SHALL be sticky until reset.
REQ-026 In DONE, rx_en and ser_in SHALL be ignored and imem_we SHALL be 0.
REQ-027 imem_addr SHALL equal cpu_pc combinationally when boot_done=1, and SHALL equal the load address otherwise.
REQ-028 cpu_dmem_we SHALL be ignored while boot_done=0.
REQ-029 When boot_done=1 and cpu_dmem_we=1, cpu_dmem_addr SHALL be pushed to the FIFO if it is not full.
REQ-030 If the FIFO is full, the store SHALL be dropped and tx_ovf SHALL be set.
REQ-031 A push and a pop in the same cycle while the FIFO is full SHALL both succeed, with no overflow.
REQ-032 TX FSM SHALL have states TX_IDLE, TX_SHIFT and TX_PAR.
REQ-033 In TX_IDLE with the FIFO non-empty, the FSM SHALL pop the head into the shift register and enter TX_SHIFT.
REQ-034 In TX_SHIFT, each cycle with tx_en=1 SHALL output one bit, MSB first, with tx_valid=1.
REQ-035 In TX_SHIFT, cycles with tx_en=0 SHALL hold the shift state and drive tx_valid=0.
REQ-036 After AW bits, the TX FSM SHALL go to TX_PAR if TX_PARITY_EN is defined, and to TX_IDLE otherwise.
REQ-037 Successive words SHALL be separated by at least one TX_IDLE cycle.

Reset
REQ-038 Asserting rst SHALL immediately set imem_we=0, imem_wdata=0, boot_done=0, tx_ser_out=0, tx_valid=0 and tx_ovf=0.
REQ-039 Asserting rst SHALL immediately clear the load address and bit counter, empty the FIFO, and return both FSMs to their reset states.
REQ-040 Reset mid-byte or mid-word SHALL discard the partial data; the load SHALL restart at address 0.

Configuration
REQ-041 Macro TX_PARITY_EN defined: state TX_PAR SHALL be present.
REQ-042 In TX_PAR, with tx_en=1, the block SHALL output the even-parity bit of the word (XOR of all AW bits) with tx_valid=1, then return to TX_IDLE.
REQ-043 Macro TX_PARITY_EN undefined: TX_PAR SHALL NOT exist and frames SHALL be exactly AW bits long.

Verification
REQ-044 LOAD_WORDS=1, DW=32, stream 0xDE,0xAD,0xBE,0xEF with rx_en=1 continuously -> writes (0,0xDE),(1,0xAD),(2,0xBE),(3,0xEF), each one cycle; boot_done=1 on the cycle after the last write.
REQ-045 Same stream with rx_en low every other cycle -> identical bytes and addresses; no bits lost.
REQ-046 After boot_done, cpu_pc=0x40 -> imem_addr=0x40 in the same cycle; bits on ser_in -> imem_we stays 0.
REQ-047 Store to 0x00000005 with tx_en=1 and AW=32 -> 32 valid bits 0...0101; with TX_PARITY_EN, a 33rd valid bit of 0.
REQ-048 FIFO_DEPTH=4, tx_en=0, six consecutive stores -> first four queued, tx_ovf=1; tx_en=1 -> exactly four frames sent, in order.
REQ-049 rst asserted mid-load after 13 bits -> outputs clear immediately; the next full byte is written at address 0.
